riscv_v_logic_unit: RTL

Multi-cycle, parametrised vector logical unit for the RISC-V V datapath. It executes the full RVV bitwise/mask-logical op set (AND, OR, XOR, NAND, NOR, XNOR, ANDN, ORN) on `NUM_ELEM` elements of `ELEM_WIDTH` bits. It processes `LANES` elements per cycle, applies v0 masking and vl tail handling with undisturbed policy, and talks to the issue and writeback stages through valid/ready handshakes.

---
 rtl/riscv_v_pkg.sv | 24 ++
 rtl/riscv_v_logic_lane.sv | 43 ++++
 rtl/riscv_v_logic_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/riscv_v_pkg.sv
// riscv_v_pkg
//   Shared types for the RISC-V V logical unit.
//   - riscv_v_logic_op_e    : 3-bit op code, result = vs2 <op> vs1
//   - riscv_v_logic_state_e : sequencing states of riscv_v_logic_unit
package riscv_v_pkg;

  typedef enum logic [2:0] {
    LOGIC_AND  = 3'd0,
    LOGIC_OR   = 3'd1,
    LOGIC_XOR  = 3'd2,
    LOGIC_NAND = 3'd3,
    LOGIC_NOR  = 3'd4,
    LOGIC_XNOR = 3'd5,
    LOGIC_ANDN = 3'd6,  // vs2 & ~vs1
    LOGIC_ORN  = 3'd7   // vs2 | ~vs1
  } riscv_v_logic_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } riscv_v_logic_state_e;

endpackage

// File: rtl/riscv_v_logic_lane.sv
// riscv_v_logic_lane
//   Combinational single-element datapath of the vector logical unit.
//   Ports:
//     op     in  3          : riscv_v_logic_op_e code
//     vs2    in  ELEM_WIDTH : first operand element
//     vs1    in  ELEM_WIDTH : second operand element
//     vd_old in  ELEM_WIDTH : previous destination element
//     active in  1          : 1 = write op result, 0 = keep vd_old
//     vd     out ELEM_WIDTH : resulting element
module riscv_v_logic_lane
  import riscv_v_pkg::*;
#(
  parameter int ELEM_WIDTH = 8
) (
  input  logic [2:0]            op,
  input  logic [ELEM_WIDTH-1:0] vs2,
  input  logic [ELEM_WIDTH-1:0] vs1,
  input  logic [ELEM_WIDTH-1:0] vd_old,
  input  logic                  active,
  output logic [ELEM_WIDTH-1:0] vd
);

  logic [ELEM_WIDTH-1:0] res;

  always_comb begin
    res = '0;
    case (riscv_v_logic_op_e'(op))
      LOGIC_AND:  res = vs2 & vs1;
      LOGIC_OR:   res = vs2 | vs1;
      LOGIC_XOR:  res = vs2 ^ vs1;
      LOGIC_NAND: res = ~(vs2 & vs1);
      LOGIC_NOR:  res = ~(vs2 | vs1);
      LOGIC_XNOR: res = ~(vs2 ^ vs1);
      LOGIC_ANDN: res = vs2 & ~vs1;
      LOGIC_ORN:  res = vs2 | ~vs1;
      default:    res = '0;
    endcase
  end

  // Inactive and tail elements are left undisturbed.
  assign vd = active ? res : vd_old;

endmodule

// File: rtl/riscv_v_logic_unit.sv
// riscv_v_logic_unit
//   Multi-cycle vector logical unit: LANES elements per cycle, BEATS cycles
//   per vector, v0 masking and vl tail handling with undisturbed policy.
//
//   Handshakes: a transfer happens on a rising clk edge where valid and
//   ready are both 1. in_ready is 1 only in IDLE; out_valid is 1 only in
//   DONE and, once high, stays high with vd stable until out_ready.
//
//   Ports:
//     clk, rst            : clock, synchronous active-high reset
//     in_valid / in_ready : request handshake
//     op                  : riscv_v_logic_op_e
//     vs1, vs2, vd_old    : operands / old destination (element i at [i*EW +: EW])
//     v0, vm              : mask bits, vm=1 means unmasked
//     vl                  : active vector length (clamped to NUM_ELEM)
//     out_valid/out_ready : result handshake
//     vd                  : result
//     dbg_state           : current FSM state (riscv_v_logic_state_e)
module riscv_v_logic_unit
  import riscv_v_pkg::*;
#(
  parameter int ELEM_WIDTH = 8,
  parameter int NUM_ELEM   = 16,
  parameter int LANES      = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [2:0]                       op,
  input  logic [NUM_ELEM*ELEM_WIDTH-1:0]   vs1,
  input  logic [NUM_ELEM*ELEM_WIDTH-1:0]   vs2,
  input  logic [NUM_ELEM*ELEM_WIDTH-1:0]   vd_old,
  input  logic [NUM_ELEM-1:0]              v0,
  input  logic                             vm,
  input  logic [$clog2(NUM_ELEM+1)-1:0]    vl,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_ELEM*ELEM_WIDTH-1:0]   vd,
  output logic [1:0]                       dbg_state
);

  localparam int BEATS = NUM_ELEM / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IW    = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
  localparam int VLW   = $clog2(NUM_ELEM + 1);
  localparam int VW    = NUM_ELEM * ELEM_WIDTH;

  localparam logic [VLW-1:0] NUM_ELEM_V = VLW'(NUM_ELEM);
  localparam logic [BW-1:0]  LAST_BEAT  = BW'(BEATS - 1);

  riscv_v_logic_state_e state_q;
  logic [BW-1:0]        beat_q;
  logic [2:0]           op_q;
  logic [VW-1:0]        vs1_q, vs2_q, vd_old_q, vd_q, vd_next;
  logic [NUM_ELEM-1:0]  v0_q;
  logic                 vm_q;
  logic [VLW-1:0]       vl_q;
  logic [VLW-1:0]       vl_eff;

  logic [IW-1:0]         elem_idx [LANES];
  logic [ELEM_WIDTH-1:0] lane_vd  [LANES];

  assign vl_eff = (vl > NUM_ELEM_V) ? NUM_ELEM_V : vl;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign vd        = vd_q;
  assign dbg_state = state_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic active;

    assign elem_idx[l] = IW'(int'(beat_q) * LANES + l);
    assign active = (VLW'(elem_idx[l]) < vl_q) && (vm_q || v0_q[elem_idx[l]]);

    riscv_v_logic_lane #(
      .ELEM_WIDTH(ELEM_WIDTH)
    ) u_lane (
      .op     (op_q),
      .vs2    (vs2_q[elem_idx[l]*ELEM_WIDTH +: ELEM_WIDTH]),
      .vs1    (vs1_q[elem_idx[l]*ELEM_WIDTH +: ELEM_WIDTH]),
      .vd_old (vd_old_q[elem_idx[l]*ELEM_WIDTH +: ELEM_WIDTH]),
      .active (active),
      .vd     (lane_vd[l])
    );
  end

  // Merge this beat's lane outputs into the current result vector.
  always_comb begin
    vd_next = vd_q;
    for (int l = 0; l < LANES; l++) begin
      vd_next[elem_idx[l]*ELEM_WIDTH +: ELEM_WIDTH] = lane_vd[l];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      op_q     <= '0;
      vs1_q    <= '0;
      vs2_q    <= '0;
      vd_old_q <= '0;
      v0_q     <= '0;
      vm_q     <= 1'b0;
      vl_q     <= '0;
      vd_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q     <= op;
            vs1_q    <= vs1;
            vs2_q    <= vs2;
            vd_old_q <= vd_old;
            v0_q     <= v0;
            vm_q     <= vm;
            vl_q     <= vl_eff;
            beat_q   <= '0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          vd_q <= vd_next;
          if (beat_q == LAST_BEAT) begin
            beat_q  <= '0;
            state_q <= DONE;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
